// File: rtl/div_iter_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_unit_pkg
// Description : Shared width constants and state encoding for the iterative
//               divider used in the E stage.
// Revision    : 1.0 - initial release
// ============================================================================
package div_iter_unit_pkg;

  // Default operand/result width; the iteration count equals this width.
  localparam int DIV_W = 32;

  // Counter must hold the value DIV_W itself, hence the +1.
  localparam int CNT_W = $clog2(DIV_W + 1);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage : div_iter_unit_pkg
`default_nettype wire

// File: rtl/div_iter_unit_div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring radix-2 division iteration (combinational).
//               Shifts {rem_in, dvd_in} left by one and trial-subtracts dvs.
//               dvd_out is the shifted dividend register with LSB left at 0;
//               the caller merges q_bit into that freed position.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] dvd_in,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_out,
  output logic [W-1:0] dvd_out,
  output logic         q_bit
);

  logic [W:0] w_rem_sh;
  logic [W:0] w_diff;

  // The shifted remainder needs W+1 bits; when its top bit is set it is
  // already >= 2^W > dvs, so the subtract always succeeds in that case.
  always_comb begin
    w_rem_sh = {rem_in, dvd_in[W-1]};
    w_diff   = w_rem_sh - {1'b0, dvs};
    q_bit    = w_rem_sh[W] | ~w_diff[W];
    rem_out  = q_bit ? w_diff[W-1:0] : w_rem_sh[W-1:0];
    dvd_out  = {dvd_in[W-2:0], 1'b0};
  end

endmodule : div_step
`default_nettype wire

// File: rtl/div_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_unit
// Description : Multi-cycle iterative DIV/DIVU unit for the E stage. Produces
//               quotient (LO) and remainder (HI), stalls the pipeline while
//               busy and honours a flush that cancels the HI/LO write.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int DATA_W = DIV_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              flush,
  output logic              div_stall,
  output logic              result_valid,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CW = $clog2(DATA_W + 1);

  div_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] prem_q, prem_d;    // partial remainder
  logic [DATA_W-1:0] dvd_q, dvd_d;      // dividend, becomes quotient bits
  logic [DATA_W-1:0] dvs_q, dvs_d;      // |divisor|
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [DATA_W-1:0] quo_q, quo_d;      // last committed LO
  logic [DATA_W-1:0] rmd_q, rmd_d;      // last committed HI

  logic [DATA_W-1:0] w_step_rem;
  logic [DATA_W-1:0] w_step_dvd;
  logic              w_step_q;
  logic [DATA_W-1:0] w_dvd_abs;
  logic [DATA_W-1:0] w_dvs_abs;
  logic [DATA_W-1:0] w_q_fix;
  logic [DATA_W-1:0] w_r_fix;

  div_step #(
    .W (DATA_W)
  ) u_step (
    .rem_in  (prem_q),
    .dvd_in  (dvd_q),
    .dvs     (dvs_q),
    .rem_out (w_step_rem),
    .dvd_out (w_step_dvd),
    .q_bit   (w_step_q)
  );

  // Operand magnitudes at acceptance and sign-fixed results at completion.
  // The most negative value negates to itself, which reads as unsigned 2^(W-1).
  always_comb begin
    w_dvd_abs = (is_signed && dividend[DATA_W-1]) ? ('0 - dividend) : dividend;
    w_dvs_abs = (is_signed && divisor[DATA_W-1])  ? ('0 - divisor)  : divisor;
    w_q_fix   = qneg_q ? ('0 - dvd_q)  : dvd_q;
    w_r_fix   = rneg_q ? ('0 - prem_q) : prem_q;
  end

  // Next-state, datapath updates and outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    prem_d       = prem_q;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    qneg_d       = qneg_q;
    rneg_d       = rneg_q;
    quo_d        = quo_q;
    rmd_d        = rmd_q;
    div_stall    = 1'b0;
    result_valid = 1'b0;
    quotient     = quo_q;
    remainder    = rmd_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (start && !flush) begin
          div_stall = 1'b1;
          dvd_d     = w_dvd_abs;
          dvs_d     = w_dvs_abs;
          qneg_d    = (dividend[DATA_W-1] ^ divisor[DATA_W-1]) & is_signed;
          rneg_d    = dividend[DATA_W-1] & is_signed;
          prem_d    = '0;
          cnt_d     = CW'(DATA_W);
          state_d   = DIV_BUSY;
        end
      end

      DIV_BUSY: begin
        if (flush) begin
          state_d = DIV_IDLE;
        end else begin
          div_stall = 1'b1;
          prem_d    = w_step_rem;
          dvd_d     = w_step_dvd | DATA_W'(w_step_q);
          cnt_d     = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DIV_DONE;
          end
        end
      end

      DIV_DONE: begin
        // Results are presented in this cycle and held afterwards; a flush
        // here suppresses both the pulse and the HI/LO update.
        state_d = DIV_IDLE;
        if (!flush) begin
          result_valid = 1'b1;
          quo_d        = w_q_fix;
          rmd_d        = w_r_fix;
          quotient     = w_q_fix;
          remainder    = w_r_fix;
        end
      end

      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end

endmodule : div_iter_unit
`default_nettype wire

// File: tb/tb_div_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_iter_unit
// Description : Self-checking bench for div_iter_unit: directed cases,
//               flush/reset behaviour, back-to-back issue and random operands
//               compared against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        div_stall;
  logic        result_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  div_iter_unit #(
    .DATA_W (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .is_signed    (is_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .flush        (flush),
    .div_stall    (div_stall),
    .result_valid (result_valid),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics from plain arithmetic.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  input bit s, output logic [31:0] q,
                                  output logic [31:0] r);
    longint x, y, qq, rr;
    if (b == 32'd0) begin
      q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
    end else begin
      x  = s ? longint'($signed(a)) : longint'({32'd0, a});
      y  = s ? longint'($signed(b)) : longint'({32'd0, b});
      qq = x / y;
      rr = x % y;
      q  = qq[31:0];
      r  = rr[31:0];
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit s);
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    #1;
  endtask

  // Counts stall cycles from the acceptance cycle, scrambling operands while
  // busy; returns positioned in the first cycle with div_stall low.
  task automatic wait_done(output int stalls);
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      if (!div_stall) break;
      stalls++;
      cycle();
      dividend  = $urandom;
      divisor   = $urandom;
      is_signed = 1'($urandom_range(0, 1));
    end
    chk("stall_released", 32'(div_stall), 32'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                        input string tag);
    logic [31:0] eq, er;
    int st;
    ref_div(a, b, s, eq, er);
    launch(a, b, s);
    wait_done(st);
    chk({tag, "_stall_cycles"}, 32'(st), 32'd33);
    chk({tag, "_valid"}, 32'(result_valid), 32'd1);
    chk({tag, "_quot"}, quotient, eq);
    chk({tag, "_rem"}, remainder, er);
    start = 1'b0;
    cycle();
    chk({tag, "_valid_drop"}, 32'(result_valid), 32'd0);
    chk({tag, "_quot_hold"}, quotient, eq);
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    int st;
    int c1;
    int c2;
    bit seen;
    logic [31:0] ra, rb;
    bit rs;

    rst = 1'b1; start = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0; flush = 1'b0;
    repeat (3) cycle();
    chk("rst_stall", 32'(div_stall), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_quot", quotient, 32'd0);
    chk("rst_rem", remainder, 32'd0);
    rst = 1'b0;
    cycle();

    // Directed cases
    run_op(32'd100, 32'd7, 1'b0, "divu_100_7");
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, "div_7_m2");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
    run_op(32'd5, 32'd0, 1'b0, "divu_by0");
    run_op(32'hFFFF_FFF0, 32'd0, 1'b1, "div_neg_by0");
    run_op(32'd12, 32'd0, 1'b1, "div_pos_by0");

    // Flush at BUSY cycle 10
    launch(32'd50, 32'd5, 1'b0);
    cycle();
    repeat (9) cycle();
    flush = 1'b1;
    start = 1'b0;
    #1;
    chk("flush_busy_stall", 32'(div_stall), 32'd0);
    chk("flush_busy_valid", 32'(result_valid), 32'd0);
    cycle();
    flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid || div_stall) seen = 1'b1;
      cycle();
    end
    chk("flush_no_result", 32'(seen), 32'd0);
    chk("flush_quot_kept", quotient, last_q);
    chk("flush_rem_kept", remainder, last_r);
    run_op(32'd9, 32'd3, 1'b0, "after_flush");

    // Flush in the DONE cycle suppresses the write
    launch(32'd77, 32'd10, 1'b0);
    wait_done(st);
    flush = 1'b1;
    start = 1'b0;
    #1;
    chk("flush_done_valid", 32'(result_valid), 32'd0);
    chk("flush_done_quot", quotient, last_q);
    cycle();
    flush = 1'b0;
    #1;
    chk("flush_done_quot_after", quotient, last_q);
    chk("flush_done_rem_after", remainder, last_r);

    // Back-to-back: next start presented right at DONE
    launch(32'd20, 32'd3, 1'b0);
    wait_done(st);
    c1 = cyc;
    chk("b2b1_valid", 32'(result_valid), 32'd1);
    chk("b2b1_quot", quotient, 32'd6);
    chk("b2b1_rem", remainder, 32'd2);
    launch(32'd9, 32'd4, 1'b0);
    cycle();
    wait_done(st);
    c2 = cyc;
    chk("b2b2_valid", 32'(result_valid), 32'd1);
    chk("b2b2_quot", quotient, 32'd2);
    chk("b2b2_rem", remainder, 32'd1);
    chk("b2b_spacing", 32'(c2 - c1), 32'd34);
    start = 1'b0;
    cycle();
    last_q = 32'd2;
    last_r = 32'd1;

    // Reset in the middle of BUSY
    launch(32'd1000, 32'd3, 1'b0);
    repeat (5) cycle();
    rst   = 1'b1;
    start = 1'b0;
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_mid_stall", 32'(div_stall), 32'd0);
    chk("rst_mid_valid", 32'(result_valid), 32'd0);
    chk("rst_mid_quot", quotient, 32'd0);
    chk("rst_mid_rem", remainder, 32'd0);
    cycle();
    run_op(32'd1000, 32'd3, 1'b0, "after_rst");

    // Random operands, with corner divisors/dividends mixed in
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case (i % 6)
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        3: ra = 32'h8000_0000;
        4: rb = rb >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op(ra, rb, rs, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_div_iter_unit
`default_nettype wire
